// File: rtl/pong_pkg.sv
// pong_pkg
// Shared screen geometry, object sizes and colours for the pong game logic
// and the VGA renderer. Also holds the coordinate type and the overlap-safe
// span test used for every rectangle hit test.
package pong_pkg;

    // 640x480@60Hz timing
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Object geometry, px
    localparam int BALL_SIZE     = 10;
    localparam int PADDLE_WIDTH  = 10;
    localparam int PADDLE_HEIGHT = 60;
    localparam int PLAYER_X      = 0;
    localparam int OPP_X         = 630;
    localparam int NET_X         = 319;
    localparam int NET_WIDTH     = 2;

    // Colours {R1,R0,G1,G0,B1,B0}
    localparam logic [5:0] COL_BALL   = 6'b111111;
    localparam logic [5:0] COL_PADDLE = 6'b001111;
    localparam logic [5:0] COL_NET    = 6'b010101;
    localparam logic [5:0] COL_BG     = 6'b000000;

    localparam int POS_W = 10;
    typedef logic [POS_W-1:0] pos_t;

    // Slot order of the four position inputs inside the renderer snapshot
    localparam int IDX_BALL_X = 0;
    localparam int IDX_BALL_Y = 1;
    localparam int IDX_PAD_Y  = 2;
    localparam int IDX_OPP_Y  = 3;
    localparam int NUM_POS    = 4;

    // Snapshot contents after reset: ball centred, paddles centred
    localparam pos_t SHADOW_RST [NUM_POS] = '{10'd315, 10'd235, 10'd210, 10'd210};

    // True when coord lies in [start, start+len-1]. The end point is formed
    // in 11 bits so an object near the top of the 10-bit range cannot wrap
    // around and light up pixels near zero.
    function automatic logic in_span(input pos_t coord, input pos_t start, input int len);
        logic [POS_W:0] c;
        logic [POS_W:0] s;
        logic [POS_W:0] e;
        c = {1'b0, coord};
        s = {1'b0, start};
        e = s + (POS_W+1)'(len - 1);
        return (c >= s) && (c <= e);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Horizontal/vertical raster counters plus the combinational decodes of the
// current counter state. All decodes are unregistered; the renderer registers
// them together with the pixel colour so they stay aligned.
// Ports:
//   clk, rst     pixel clock, synchronous active-high reset
//   hc, vc       current column / line
//   hsync_raw    active-low horizontal sync for (hc,vc)
//   vsync_raw    active-low vertical sync for (hc,vc)
//   active       (hc,vc) is inside the visible area
//   frame_tick   high for the single cycle with hc=0, vc=V_ACTIVE
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic          clk,
    input  logic          rst,
    output pong_pkg::pos_t hc,
    output pong_pkg::pos_t vc,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          active,
    output logic          frame_tick
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    pong_pkg::pos_t hc_reg;
    pong_pkg::pos_t vc_reg;
    pong_pkg::pos_t hc_next;
    pong_pkg::pos_t vc_next;

    always_comb begin
        hc_next = hc_reg + pong_pkg::pos_t'(1);
        vc_next = vc_reg;
        if (hc_reg == pong_pkg::pos_t'(H_TOTAL - 1)) begin
            hc_next = '0;
            if (vc_reg == pong_pkg::pos_t'(V_TOTAL - 1)) begin
                vc_next = '0;
            end else begin
                vc_next = vc_reg + pong_pkg::pos_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_reg <= '0;
            vc_reg <= '0;
        end else begin
            hc_reg <= hc_next;
            vc_reg <= vc_next;
        end
    end

    assign hc = hc_reg;
    assign vc = vc_reg;

    assign hsync_raw = !((hc_reg >= pong_pkg::pos_t'(HS_FIRST)) &&
                         (hc_reg <= pong_pkg::pos_t'(HS_LAST)));
    assign vsync_raw = !((vc_reg >= pong_pkg::pos_t'(VS_FIRST)) &&
                         (vc_reg <= pong_pkg::pos_t'(VS_LAST)));
    assign active    = (hc_reg < pong_pkg::pos_t'(H_ACTIVE)) &&
                       (vc_reg < pong_pkg::pos_t'(V_ACTIVE));
    assign frame_tick = (hc_reg == '0) && (vc_reg == pong_pkg::pos_t'(V_ACTIVE));

endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer
// Draws ball, both paddles and a dashed centre net as VGA video. Positions
// are frozen into a snapshot once per frame (at frame_tick, the first
// blanking line) so the game can update them at any time without tearing.
// frame_tick doubles as the game's step strobe.
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   ball_x/y      ball top-left, px
//   paddle_y      player paddle top, px
//   opp_paddle_y  opponent paddle top, px
//   hsync, vsync  active-low syncs, registered
//   rgb           {R1,R0,G1,G0,B1,B0}, registered, zero outside active area
//   display_on    registered active-area flag, aligned with rgb
//   frame_tick    one-cycle pulse at hc=0, vc=V_ACTIVE
module pong_vga_renderer
    import pong_pkg::*;
#(
    parameter int H_ACTIVE = pong_pkg::H_ACTIVE,
    parameter int H_FP     = pong_pkg::H_FP,
    parameter int H_SYNC   = pong_pkg::H_SYNC,
    parameter int H_BP     = pong_pkg::H_BP,
    parameter int V_ACTIVE = pong_pkg::V_ACTIVE,
    parameter int V_FP     = pong_pkg::V_FP,
    parameter int V_SYNC   = pong_pkg::V_SYNC,
    parameter int V_BP     = pong_pkg::V_BP,
    parameter int PLAYER_X = pong_pkg::PLAYER_X,
    parameter int OPP_X    = H_ACTIVE - pong_pkg::PADDLE_WIDTH,
    parameter int NET_X    = H_ACTIVE / 2 - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
    input  logic [9:0] opp_paddle_y,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       display_on,
    output logic       frame_tick
);

    pos_t hc;
    pos_t vc;
    logic hsync_raw;
    logic vsync_raw;
    logic active;
    logic tick;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .hc         (hc),
        .vc         (vc),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw),
        .active     (active),
        .frame_tick (tick)
    );

    // ---------------------------------------------------------------
    // Per-frame snapshot of the game positions
    // ---------------------------------------------------------------
    pos_t pos_in [NUM_POS];
    pos_t shadow [NUM_POS];

    assign pos_in[IDX_BALL_X] = ball_x;
    assign pos_in[IDX_BALL_Y] = ball_y;
    assign pos_in[IDX_PAD_Y]  = paddle_y;
    assign pos_in[IDX_OPP_Y]  = opp_paddle_y;

    for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_shadow
        pos_t val_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                val_reg <= SHADOW_RST[gi];
            end else if (tick) begin
                val_reg <= pos_in[gi];
            end
        end

        assign shadow[gi] = val_reg;
    end

    // ---------------------------------------------------------------
    // Hit tests against the snapshot
    // ---------------------------------------------------------------
    logic ball_hit;
    logic player_hit;
    logic opp_hit;
    logic net_hit;

    assign ball_hit   = in_span(hc, shadow[IDX_BALL_X], BALL_SIZE) &&
                        in_span(vc, shadow[IDX_BALL_Y], BALL_SIZE);
    assign player_hit = in_span(hc, pos_t'(PLAYER_X), PADDLE_WIDTH) &&
                        in_span(vc, shadow[IDX_PAD_Y], PADDLE_HEIGHT);
    assign opp_hit    = in_span(hc, pos_t'(OPP_X), PADDLE_WIDTH) &&
                        in_span(vc, shadow[IDX_OPP_Y], PADDLE_HEIGHT);
    // Net is dashed in 16-line segments: drawn while line bit 4 is clear
    assign net_hit    = in_span(hc, pos_t'(NET_X), NET_WIDTH) && (vc[4] == 1'b0);

    // ---------------------------------------------------------------
    // Priority compositor
    // ---------------------------------------------------------------
    logic [5:0] rgb_next;

    always_comb begin
        rgb_next = COL_BG;
        if (active) begin
            if (ball_hit) begin
                rgb_next = COL_BALL;
            end else if (player_hit || opp_hit) begin
                rgb_next = COL_PADDLE;
            end else if (net_hit) begin
                rgb_next = COL_NET;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output register: syncs, active flag and colour share one stage so
    // they all describe the same raster position.
    // ---------------------------------------------------------------
    logic       hsync_reg;
    logic       vsync_reg;
    logic [5:0] rgb_reg;
    logic       display_on_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_reg      <= 1'b1;
            vsync_reg      <= 1'b1;
            rgb_reg        <= COL_BG;
            display_on_reg <= 1'b0;
        end else begin
            hsync_reg      <= hsync_raw;
            vsync_reg      <= vsync_raw;
            rgb_reg        <= rgb_next;
            display_on_reg <= active;
        end
    end

    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign rgb        = rgb_reg;
    assign display_on = display_on_reg;
    assign frame_tick = tick;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer
// Directed checks of the renderer on a scaled-down raster (96x64 visible,
// 120x72 total) so that several whole frames fit in a short run.
// cyc counts clock periods since reset release; the registered outputs seen
// in period cyc describe raster position (cyc-1) mod FRAME.
module tb_pong_vga_renderer;

    localparam int HA   = 96;
    localparam int HFP  = 4;
    localparam int HS   = 12;
    localparam int HBP  = 8;
    localparam int HT   = 120;
    localparam int VA   = 64;
    localparam int VFP  = 2;
    localparam int VS   = 2;
    localparam int VBP  = 4;
    localparam int VT   = 72;
    localparam int F    = HT * VT;   // 8640 cycles per frame
    localparam int TICK = VA * HT;   // 7680: first frame_tick after reset

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] ball_x = 10'd40;
    logic [9:0] ball_y = 10'd30;
    logic [9:0] paddle_y = 10'd2;
    logic [9:0] opp_paddle_y = 10'd10;
    logic       hsync;
    logic       vsync;
    logic [5:0] rgb;
    logic       display_on;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    pong_vga_renderer #(
        .H_ACTIVE (HA),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .paddle_y     (paddle_y),
        .opp_paddle_y (opp_paddle_y),
        .hsync        (hsync),
        .vsync        (vsync),
        .rgb          (rgb),
        .display_on   (display_on),
        .frame_tick   (frame_tick)
    );

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Advance until the outputs show raster pixel (x,y); bounded by one frame.
    task automatic goto(input int x, input int y);
        int t;
        t = y * HT + x;
        for (int k = 0; k <= F + 1; k++) begin
            if (cyc >= 1 && ((cyc - 1) % F) == t) return;
            step();
        end
        total++;
        bad++;
        $display("FAIL goto_bound pixel=(%0d,%0d) cyc=%0d", x, y, cyc);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total += 5;
        if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b want=1", hsync); end
        if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b want=1", vsync); end
        if (rgb !== 6'h00) begin bad++; $display("FAIL reset_rgb got=%h want=00", rgb); end
        if (display_on !== 1'b0) begin bad++; $display("FAIL reset_display_on got=%b want=0", display_on); end
        if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_frame_tick got=%b want=0", frame_tick); end
        $display("reset: hsync=%b vsync=%b rgb=%h de=%b tick=%b", hsync, vsync, rgb, display_on, frame_tick);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Two whole frames: sync/active placement and counts, frame_tick
    // timing, and frame 0 drawn from the reset snapshot (everything off
    // screen on this raster, so only the net shows).
    task automatic test_timing();
        int hs_low = 0, vs_low = 0, de_cnt = 0, tick_n = 0;
        int hs_err = 0, vs_err = 0, de_err = 0, rgb_err = 0;
        int tick_at [2];
        int p, h, v;
        logic exp_hs, exp_vs, exp_de;
        logic [5:0] exp_rgb;
        tick_at[0] = -1;
        tick_at[1] = -1;
        while (cyc <= 2 * F) begin
            if (frame_tick === 1'b1) begin
                if (tick_n < 2) tick_at[tick_n] = cyc;
                tick_n++;
            end
            if (cyc >= 1) begin
                p = (cyc - 1) % F;
                h = p % HT;
                v = p / HT;
                exp_hs = !(h >= 100 && h <= 111);
                exp_vs = !(v >= 66 && v <= 67);
                exp_de = (h < HA) && (v < VA);
                if (hsync === 1'b0) hs_low++;
                if (vsync === 1'b0) vs_low++;
                if (display_on === 1'b1) de_cnt++;
                if (hsync !== exp_hs) hs_err++;
                if (vsync !== exp_vs) vs_err++;
                if (display_on !== exp_de) de_err++;
                if (cyc - 1 < F) begin
                    exp_rgb = (exp_de && (h == 47 || h == 48) && ((v / 16) % 2 == 0)) ? 6'h15 : 6'h00;
                    if (rgb !== exp_rgb) rgb_err++;
                end else if (!exp_de && rgb !== 6'h00) begin
                    rgb_err++;
                end
            end
            step();
        end
        total += 10;
        if (hs_low !== 1728) begin bad++; $display("FAIL hsync_low_count got=%0d want=1728", hs_low); end
        if (vs_low !== 480) begin bad++; $display("FAIL vsync_low_count got=%0d want=480", vs_low); end
        if (de_cnt !== 12288) begin bad++; $display("FAIL display_on_count got=%0d want=12288", de_cnt); end
        if (hs_err !== 0) begin bad++; $display("FAIL hsync_placement errors=%0d want=0", hs_err); end
        if (vs_err !== 0) begin bad++; $display("FAIL vsync_placement errors=%0d want=0", vs_err); end
        if (de_err !== 0) begin bad++; $display("FAIL display_on_placement errors=%0d want=0", de_err); end
        if (rgb_err !== 0) begin bad++; $display("FAIL frame0_rgb errors=%0d want=0", rgb_err); end
        if (tick_n !== 2) begin bad++; $display("FAIL frame_tick_count got=%0d want=2", tick_n); end
        if (tick_at[0] !== TICK) begin bad++; $display("FAIL frame_tick_first got=%0d want=%0d", tick_at[0], TICK); end
        if (tick_at[1] !== F + TICK) begin bad++; $display("FAIL frame_tick_second got=%0d want=%0d", tick_at[1], F + TICK); end
        $display("timing: hs_low=%0d vs_low=%0d de=%0d ticks=%0d at %0d,%0d", hs_low, vs_low, de_cnt, tick_n, tick_at[0], tick_at[1]);
    endtask

    // Frame 2: ball (40,30), player paddle y=2, opponent y=10.
    task automatic test_ball();
        int vx [12];
        int vy [12];
        logic [5:0] vr [12];
        vx = '{47, 47, 88,  0, 39, 40, 49, 50, 47, 49, 40, 48};
        vy = '{ 5, 20, 20, 30, 30, 30, 30, 30, 35, 39, 40, 40};
        vr = '{6'h15, 6'h00, 6'h0F, 6'h0F, 6'h00, 6'h3F, 6'h3F, 6'h00, 6'h3F, 6'h3F, 6'h00, 6'h15};
        for (int i = 0; i < 12; i++) begin
            goto(vx[i], vy[i]);
            total++;
            if (rgb !== vr[i] || display_on !== 1'b1) begin
                bad++;
                $display("FAIL ball_pixel (%0d,%0d) rgb=%h de=%b want rgb=%h de=1", vx[i], vy[i], rgb, display_on, vr[i]);
            end else begin
                $display("ball pixel (%0d,%0d) rgb=%h", vx[i], vy[i], rgb);
            end
        end
        ball_y = 10'd50;
    endtask

    // Frame 3 snapshot is ball (40,50); x moves to 70 at line 20 and must
    // only take effect in frame 4.
    task automatic test_midframe();
        int vx [6];
        int vy [6];
        logic [5:0] vr [6];
        vx = '{40, 70, 49, 40, 70, 79};
        vy = '{50, 50, 59, 50, 50, 59};
        vr = '{6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h3F};
        goto(0, 20);
        ball_x = 10'd70;
        for (int i = 0; i < 6; i++) begin
            goto(vx[i], vy[i]);
            total++;
            if (rgb !== vr[i]) begin
                bad++;
                $display("FAIL midframe_pixel #%0d (%0d,%0d) rgb=%h want=%h", i, vx[i], vy[i], rgb, vr[i]);
            end else begin
                $display("midframe pixel #%0d (%0d,%0d) rgb=%h", i, vx[i], vy[i], rgb);
            end
        end
        ball_x = 10'd5;
        ball_y = 10'd20;
        paddle_y = 10'd10;
        opp_paddle_y = 10'd1020;
    endtask

    // Frame 5: ball (5,20) over player paddle y=10; opponent far off screen.
    task automatic test_overlap();
        int vx [10];
        int vy [10];
        logic [5:0] vr [10];
        vx = '{ 0,  9, 10, 88,  5,  4,  9, 12, 15,  5};
        vy = '{10, 10, 10, 10, 20, 25, 25, 25, 25, 30};
        vr = '{6'h0F, 6'h0F, 6'h00, 6'h00, 6'h3F, 6'h0F, 6'h3F, 6'h3F, 6'h00, 6'h0F};
        for (int i = 0; i < 10; i++) begin
            goto(vx[i], vy[i]);
            total++;
            if (rgb !== vr[i]) begin
                bad++;
                $display("FAIL overlap_pixel (%0d,%0d) rgb=%h want=%h", vx[i], vy[i], rgb, vr[i]);
            end else begin
                $display("overlap pixel (%0d,%0d) rgb=%h", vx[i], vy[i], rgb);
            end
        end
        goto(9, 63);
        total++;
        if (rgb !== 6'h0F) begin bad++; $display("FAIL paddle_bottom rgb=%h want=0f", rgb); end
        else $display("paddle bottom (9,63) rgb=%h", rgb);
        ball_x = 10'd91;
        ball_y = 10'd59;
        paddle_y = 10'd100;
        opp_paddle_y = 10'd300;
    endtask

    // Frame 6/7: ball (91,59) crosses both the right and bottom edges.
    task automatic test_edge_clip();
        int vx [11];
        int vy [11];
        logic [5:0] vr [11];
        logic vd [11];
        vx = '{90, 91, 95, 96, 100,  0, 95, 91,  0, 91, 95};
        vy = '{59, 59, 59, 59,  59, 60, 63, 64, 65,  0,  3};
        vr = '{6'h00, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00};
        vd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            goto(vx[i], vy[i]);
            total++;
            if (rgb !== vr[i] || display_on !== vd[i]) begin
                bad++;
                $display("FAIL edge_pixel #%0d (%0d,%0d) rgb=%h de=%b want rgb=%h de=%b", i, vx[i], vy[i], rgb, display_on, vr[i], vd[i]);
            end else begin
                $display("edge pixel #%0d (%0d,%0d) rgb=%h de=%b", i, vx[i], vy[i], rgb, display_on);
            end
        end
    endtask

    // Reset inside an hsync pulse mid-frame; timing and snapshot restart.
    task automatic test_reset_midframe();
        goto(105, 40);
        total++;
        if (hsync !== 1'b0) begin bad++; $display("FAIL pre_reset_hsync got=%b want=0", hsync); end
        rst = 1'b1;
        step();
        total += 5;
        if (hsync !== 1'b1) begin bad++; $display("FAIL midreset_hsync got=%b want=1", hsync); end
        if (vsync !== 1'b1) begin bad++; $display("FAIL midreset_vsync got=%b want=1", vsync); end
        if (rgb !== 6'h00) begin bad++; $display("FAIL midreset_rgb got=%h want=00", rgb); end
        if (display_on !== 1'b0) begin bad++; $display("FAIL midreset_display_on got=%b want=0", display_on); end
        if (frame_tick !== 1'b0) begin bad++; $display("FAIL midreset_frame_tick got=%b want=0", frame_tick); end
        $display("mid-frame reset: hsync=%b vsync=%b rgb=%h de=%b", hsync, vsync, rgb, display_on);
        step();
        rst = 1'b0;
        cyc = 0;
        step();
        total++;
        if (display_on !== 1'b1 || hsync !== 1'b1) begin
            bad++;
            $display("FAIL restart_pixel00 de=%b hsync=%b want de=1 hsync=1", display_on, hsync);
        end
        goto(91, 59);
        total++;
        if (rgb !== 6'h00) begin bad++; $display("FAIL restart_snapshot rgb=%h want=00", rgb); end
        else $display("restart snapshot (91,59) rgb=%h", rgb);
        while (frame_tick !== 1'b1 && cyc < TICK + HT) step();
        total++;
        if (frame_tick !== 1'b1 || cyc !== TICK) begin
            bad++;
            $display("FAIL restart_frame_tick tick=%b cyc=%0d want tick=1 cyc=%0d", frame_tick, cyc, TICK);
        end else begin
            $display("restart frame_tick at cyc=%0d", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_ball();
        test_midframe();
        test_overlap();
        test_edge_clip();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
